// File: rtl/store_pkg.sv
// Shared types for the buffered store path: queue entry layout, dump FSM states
// and the vector lane count.
package store_pkg;
    localparam int S         = 32;
    localparam int V         = 192;
    localparam int VEC_LANES = 6;

    typedef struct packed {
        logic         isVector;
        logic [S-1:0] address;
        logic [V-1:0] wd;
    } store_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        PULSE,
        HOLD
    } dump_state_t;
endpackage

// File: rtl/store_fifo.sv
// DEPTH-entry FIFO of store entries; the caller never pushes when full nor pops
// when empty, so no overflow protection is kept here.
module store_fifo
    import store_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  store_entry_t  wdata_i,
    output store_entry_t  rdata_o,
    output logic [CW-1:0] count_o
);
    store_entry_t  mem_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[tail_q] <= wdata_i;
    end

    // Pointers are log2(DEPTH) wide so they wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + PW'(1);
            if (pop_i)  head_q <= head_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[head_q];
    assign count_o = count_q;
endmodule

// File: rtl/store_queue.sv
// Store queue between the memory stage and dmem_ram: range-checked push, one
// retire per cycle into registered RAM inputs, and the drain-then-dump sequence.
//
//   state | meaning
//   IDLE  | accepting stores
//   DRAIN | intake closed, waiting for queue and last RAM write to finish
//   PULSE | switchStart high for one cycle
//   HOLD  | waiting for dump_req to drop
module store_queue
    import store_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter int  SIZE  = 30015,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_isVector,
    input  logic [S-1:0]  in_address,
    input  logic [V-1:0]  in_wd,
    input  logic          dump_req,
    output logic          mem_we,
    output logic          mem_isVector,
    output logic [S-1:0]  mem_address,
    output logic [V-1:0]  mem_wd,
    output logic          switchStart,
    output logic [CW-1:0] count,
    output logic          range_err
);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [S:0]    SIZE_C    = (S+1)'(SIZE);
    localparam logic [S:0]    LAST_LANE = (S+1)'(VEC_LANES - 1);

    dump_state_t   state_q, state_d;
    store_entry_t  push_entry, head_entry;
    logic [CW-1:0] fifo_count;
    logic [S:0]    end_addr;
    logic          in_range, accept, push, pop;
    logic          mem_we_q, mem_isvec_q, range_err_q;
    logic [S-1:0]  mem_addr_q;
    logic [V-1:0]  mem_wd_q;

    // One extra bit so a vector near the top of the address space cannot wrap.
    assign end_addr   = {1'b0, in_address} + (in_isVector ? LAST_LANE : '0);
    assign in_range   = end_addr < SIZE_C;
    assign in_ready   = (fifo_count < DEPTH_C) && (state_q == IDLE);
    assign accept     = in_valid && in_ready;
    assign push       = accept && in_range;
    assign pop        = fifo_count != '0;
    assign push_entry = '{isVector: in_isVector, address: in_address, wd: in_wd};

    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we_q    <= 1'b0;
            mem_isvec_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wd_q    <= '0;
            range_err_q <= 1'b0;
        end else begin
            mem_we_q <= pop;
            if (pop) begin
                mem_isvec_q <= head_entry.isVector;
                mem_addr_q  <= head_entry.address;
                mem_wd_q    <= head_entry.wd;
            end
            if (accept && !in_range) range_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Leaving DRAIN waits for mem_we to fall too, giving the RAM a full idle
    // cycle after the last write before the dump edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dump_req) state_d = DRAIN;
            DRAIN:   if (fifo_count == '0 && !mem_we_q) state_d = PULSE;
            PULSE:   state_d = HOLD;
            HOLD:    if (!dump_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign switchStart  = (state_q == PULSE);
    assign mem_we       = mem_we_q;
    assign mem_isVector = mem_isvec_q;
    assign mem_address  = mem_addr_q;
    assign mem_wd       = mem_wd_q;
    assign count        = fifo_count;
    assign range_err    = range_err_q;
endmodule

// File: tb/tb_store_queue.sv
// Randomised and directed bench for store_queue with an occupancy-level model
// and a scoreboard of expected RAM writes drained by an output monitor.
module tb_store_queue;
    import store_pkg::*;

    localparam int DEPTH = 4;
    localparam int SIZE  = 30015;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_isVector = 1'b0;
    logic [S-1:0]  in_address = '0;
    logic [V-1:0]  in_wd = '0;
    logic          dump_req = 1'b0;
    logic          mem_we, mem_isVector, switchStart, range_err;
    logic [S-1:0]  mem_address;
    logic [V-1:0]  mem_wd;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    store_queue #(.DEPTH(DEPTH), .SIZE(SIZE)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_isVector  (in_isVector),
        .in_address   (in_address),
        .in_wd        (in_wd),
        .dump_req     (dump_req),
        .mem_we       (mem_we),
        .mem_isVector (mem_isVector),
        .mem_address  (mem_address),
        .mem_wd       (mem_wd),
        .switchStart  (switchStart),
        .count        (count),
        .range_err    (range_err)
    );

    typedef struct {
        bit              vec;
        logic [S-1:0]    addr;
        logic [V-1:0]    wd;
    } req_t;

    req_t        exp_q[$];
    logic [31:0] ram [int];
    int n_vec = 0;
    int n_mis = 0;

    // Reference model: occupancy, pending-write flag, dump phase, sticky error.
    int occ = 0;
    bit we_m = 0;
    int phase = 0;   // 0 idle, 1 draining, 2 pulse, 3 holding
    bit rerr_m = 0;
    bit acc_last = 0;
    int pulses = 0;

    task automatic check(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return (occ < DEPTH) && (phase == 0);
    endfunction

    task automatic model_clear();
        occ = 0; we_m = 0; phase = 0; rerr_m = 0; acc_last = 0;
        exp_q.delete();
    endtask

    always @(posedge clk) begin
        if (reset) begin
            model_clear();
        end else begin
            bit acc, ok, pop;
            int nphase;
            acc = in_valid && model_ready();
            ok  = (longint'(in_address) + (in_isVector ? 5 : 0)) < longint'(SIZE);
            acc_last = acc;
            if (acc && !ok) rerr_m = 1;
            if (acc && ok) exp_q.push_back('{in_isVector, in_address, in_wd});
            pop = occ > 0;
            nphase = phase;
            case (phase)
                0: if (dump_req) nphase = 1;
                1: if (occ == 0 && !we_m) nphase = 2;
                2: nphase = 3;
                3: if (!dump_req) nphase = 0;
                default: nphase = 0;
            endcase
            we_m  = pop;
            occ   = occ - (pop ? 1 : 0) + ((acc && ok) ? 1 : 0);
            phase = nphase;
        end
    end

    // Cycle-level checks of control outputs.
    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready", in_ready, model_ready());
            check("count", count, occ);
            check("mem_we", mem_we, we_m);
            check("switchStart", switchStart, phase == 2);
            check("range_err", range_err, rerr_m);
            if (switchStart) pulses++;
        end
    end

    // Scoreboard monitor: every RAM write must match the next expected store.
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_mis++;
                $display("FAIL unexpected_write: got write to %0d expected no write", mem_address);
            end else begin
                req_t e;
                e = exp_q.pop_front();
                check("wr_addr", mem_address, e.addr);
                check("wr_isVector", mem_isVector, e.vec);
                check("wr_data", mem_wd, e.wd);
            end
            if (mem_isVector) begin
                for (int i = 0; i < VEC_LANES; i++) ram[int'(mem_address) + i] = mem_wd[32*i +: 32];
            end else begin
                ram[int'(mem_address)] = mem_wd[31:0];
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send(input bit vec, input int unsigned addr, input logic [V-1:0] wd);
        @(negedge clk);
        in_valid    = 1'b1;
        in_isVector = vec;
        in_address  = addr;
        in_wd       = wd;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            #1;
            if (acc_last) return;
        end
        n_vec++; n_mis++;
        $display("FAIL send_timeout: got no handshake expected accept for addr %0d", addr);
    endtask

    function automatic logic [31:0] ram_rd(input int a);
        return ram.exists(a) ? ram[a] : 32'hxxxx_xxxx;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_mem_we"}, mem_we, 1'b0);
        check({tag, "_mem_isVector"}, mem_isVector, 1'b0);
        check({tag, "_mem_address"}, mem_address, '0);
        check({tag, "_mem_wd"}, mem_wd, '0);
        check({tag, "_switchStart"}, switchStart, 1'b0);
        check({tag, "_count"}, count, '0);
        check({tag, "_range_err"}, range_err, 1'b0);
    endtask

    initial begin
        logic [V-1:0] wd;
        #1;
        check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Scalar store.
        wd = '0; wd[31:0] = 32'hDEADBEEF;
        send(0, 10, wd);
        idle(4);
        check("ram_scalar10", ram_rd(10), 32'hDEADBEEF);

        // Vector store, lanes 1..6.
        for (int i = 0; i < VEC_LANES; i++) wd[32*i +: 32] = 32'(i + 1);
        send(1, 100, wd);
        idle(4);
        for (int i = 0; i < VEC_LANES; i++) check("ram_vec", ram_rd(100 + i), 32'(i + 1));

        // Back-to-back pushes with retire running.
        for (int k = 0; k < 6; k++) begin
            wd = '0; wd[31:0] = 32'hA000 + 32'(k);
            send(0, 32'(500 + k), wd);
        end
        idle(4);
        for (int k = 0; k < 6; k++) check("ram_b2b", ram_rd(500 + k), 32'hA000 + 32'(k));

        // Range boundary.
        wd = '0; wd[31:0] = 32'h1234_5678;
        send(1, 30010, wd);
        idle(3);
        check("range_err_set", range_err, 1'b1);
        check("range_dropped", ram.exists(30010), 1'b0);
        send(0, 30014, wd);
        idle(3);
        check("ram_top", ram_rd(30014), 32'h1234_5678);

        // Dump sequence with three stores queued.
        for (int k = 0; k < 3; k++) begin
            wd = '0; wd[31:0] = 32'hD000 + 32'(k);
            send(0, 32'(700 + k), wd);
        end
        @(negedge clk);
        in_valid = 1'b0;
        dump_req = 1'b1;
        pulses = 0;
        repeat (12) @(negedge clk);
        check("dump_pulses", pulses, 1);
        check("dump_hold_ready", in_ready, 1'b0);
        for (int k = 0; k < 3; k++) check("ram_dump", ram_rd(700 + k), 32'hD000 + 32'(k));
        dump_req = 1'b0;
        repeat (2) @(negedge clk);
        check("dump_release_ready", in_ready, 1'b1);

        // Random traffic with occasional dumps.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_valid    = ($urandom % 4) != 0;
            in_isVector = $urandom % 2;
            in_address  = ($urandom % 3 == 0) ? 32'(SIZE - 8 + $urandom % 10) : 32'($urandom % SIZE);
            for (int i = 0; i < VEC_LANES; i++) in_wd[32*i +: 32] = $urandom;
            dump_req = ($urandom % 64 == 0) ? 1'b1 : (dump_req && ($urandom % 16 != 0));
        end
        @(negedge clk);
        in_valid = 1'b0;
        dump_req = 1'b0;
        idle(12);
        check("scoreboard_empty", exp_q.size(), 0);

        // Reset while draining.
        ram.delete();
        wd = '0; wd[31:0] = 32'hBAD0_0001;
        @(negedge clk);
        in_valid = 1'b1; in_isVector = 1'b0; in_address = 200; in_wd = wd;
        dump_req = 1'b1;
        @(posedge clk);
        #2;
        check("pre_reset_drain", phase, 1);
        check("pre_reset_count", count, 1);
        reset = 1'b1;
        model_clear();
        in_valid = 1'b0;
        dump_req = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        idle(10);
        check("post_reset_pulses", pulses, 0);
        check("post_reset_nowrite", ram.exists(200), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
